// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared types and constants for the AES block packer
//
// Purpose: block geometry, byte/block/count types and the packer state enum.
// Block byte 0 sits in the most significant byte, i.e. element BLOCK_BYTES-1
// of block_t; slot() maps a byte index to its element.
package aes_pkg;

  localparam int BLOCK_BYTES = 16;
  localparam int CNT_BITS    = 4;

  typedef logic [7:0]                   byte_t;
  typedef byte_t [BLOCK_BYTES-1:0]      block_t;
  typedef logic [CNT_BITS-1:0]          cnt_t;

  typedef enum logic [1:0] {
    FILL,
    PAD,
    HOLD
  } state_t;

  // Byte index 0 lands in [127:120], so element number counts down.
  function automatic cnt_t slot(input cnt_t idx);
    return cnt_t'(BLOCK_BYTES - 1) - idx;
  endfunction

endpackage

// File: rtl/aes_block_packer_if.sv
// rtl/aes_block_packer_if.sv - block-side valid/ready handshake bundle
//
// Purpose: carries the assembled block toward the AES core.
// Signals: block_out (128, byte 0 in [127:120]), block_valid, block_ready.
// master: the packer (drives block_out/block_valid); slave: the AES core.
interface aes_block_packer_if;
  import aes_pkg::*;

  block_t block_out;
  logic   block_valid;
  logic   block_ready;

  modport master (output block_out, output block_valid, input block_ready);
  modport slave  (input block_out, input block_valid, output block_ready);

endinterface

// File: rtl/aes_pad_gen.sv
// rtl/aes_pad_gen.sv - pads bytes byte_cnt..15 of a partial block
//
// Purpose: combinational pad generator used by the packer PAD state.
// Ports: byte_cnt (in, bytes already captured), block_in (in, current block),
//        block_padded (out, block with the tail overwritten by the pad byte).
// Macro: AES_PACKER_PKCS7_EN - defined: pad byte = BLOCK_BYTES - byte_cnt
//        (PKCS#7); undefined: pad byte = 0x00.
module aes_pad_gen
  import aes_pkg::*;
(
  input  cnt_t   byte_cnt,
  input  block_t block_in,
  output block_t block_padded
);

  byte_t pad_byte;

`ifdef AES_PACKER_PKCS7_EN
  assign pad_byte = byte_t'(BLOCK_BYTES - int'(byte_cnt));
`else
  assign pad_byte = '0;
`endif

  always_comb begin
    block_padded = block_in;
    for (int i = 0; i < BLOCK_BYTES; i++) begin
      if (i >= int'(byte_cnt)) begin
        block_padded[BLOCK_BYTES-1-i] = pad_byte;
      end
    end
  end

endmodule

// File: rtl/aes_block_packer.sv
// rtl/aes_block_packer.sv - packs FIFO bytes into 128-bit AES plaintext blocks
//
// Purpose: pops bytes from a first-word-fall-through FIFO, assembles 16-byte
// blocks, pads a partial block on flush and offers it over valid/ready.
// Ports: clk, n_rst (async active-low); fifo_empty/fifo_rdata in,
//        fifo_renable out (combinational pop); flush in (level),
//        flush_done out (1-cycle pulse); byte_cnt out; blk (master modport:
//        block_out, block_valid, block_ready).
// Padding style is selected by AES_PACKER_PKCS7_EN inside aes_pad_gen.
module aes_block_packer
  import aes_pkg::*;
(
  input  logic                clk,
  input  logic                n_rst,
  input  logic                fifo_empty,
  input  byte_t               fifo_rdata,
  output logic                fifo_renable,
  input  logic                flush,
  output logic                flush_done,
  output cnt_t                byte_cnt,
  aes_block_packer_if.master  blk
);

  state_t state_q, state_d;
  cnt_t   byte_cnt_q, byte_cnt_d;
  block_t block_q, block_d;
  logic   valid_q, valid_d;
  logic   done_q, done_d;
  block_t block_padded;

  aes_pad_gen u_pad_gen (
    .byte_cnt     (byte_cnt_q),
    .block_in     (block_q),
    .block_padded (block_padded)
  );

  // Gated by n_rst so nothing is popped while the block is held in reset.
  assign fifo_renable    = n_rst && (state_q == FILL) && !fifo_empty;
  assign flush_done      = done_q;
  assign byte_cnt        = byte_cnt_q;
  assign blk.block_out   = block_q;
  assign blk.block_valid = valid_q;

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    block_d    = block_q;
    valid_d    = valid_q;
    done_d     = 1'b0;
    case (state_q)
      FILL: begin
        if (!fifo_empty) begin
          block_d[slot(byte_cnt_q)] = fifo_rdata;
          byte_cnt_d = byte_cnt_q + 1'b1;          // wraps to 0 after byte 15
          if (byte_cnt_q == cnt_t'(BLOCK_BYTES - 1)) begin
            state_d = HOLD;
            valid_d = 1'b1;
          end
        end else if (flush && !done_q) begin
          // done_q masks the cycle where flush is still held after an
          // empty-flush acknowledge, so it is not acknowledged twice.
          done_d = 1'b1;
          if (byte_cnt_q != '0) begin
            state_d = PAD;
          end
        end
      end
      PAD: begin
        block_d    = block_padded;
        byte_cnt_d = '0;
        valid_d    = 1'b1;
        state_d    = HOLD;
      end
      HOLD: begin
        if (blk.block_ready) begin
          block_d    = '0;
          byte_cnt_d = '0;
          valid_d    = 1'b0;
          state_d    = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= FILL;
      byte_cnt_q <= '0;
      block_q    <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      block_q    <= block_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: doc/aes_block_packer.md
# aes_block_packer

Drains bytes from the upstream packet byte FIFO and assembles them into 128-bit AES plaintext blocks for the encryption core. It sits between the byte FIFO (first-word fall-through, read data valid whenever not empty) and the AES core input, with a valid/ready handshake on the block side. On an end-of-packet flush it pads a partial block and hands it on.

## Interface
- BLOCK_BYTES, 16, bytes per AES block; fixed at 16 for AES-128.
- CNT_BITS, 4, width of the byte index; equals clog2(BLOCK_BYTES).
- Reset is n_rst, asynchronous, active-low; the clock is clk.
- clk  in  1  clock.
- n_rst  in  1  asynchronous active-low reset.
- fifo_empty  in  1  upstream FIFO empty flag.
- fifo_rdata  in  8  upstream FIFO head byte; valid when fifo_empty=0.
- fifo_renable  out  1  pop request to the FIFO; combinational.
- flush  in  1  end-of-packet request; a level held by the source until flush_done.
- flush_done  out  1  one-cycle pulse acknowledging flush.
- block_out  out  128  assembled block; byte 0 in [127:120].
- block_valid  out  1  block_out holds a complete block.
- block_ready  in  1  AES core accepts the block.
- byte_cnt  out  CNT_BITS  number of bytes captured in the current block.

## Operation
- States are FILL, PAD and HOLD. Reset enters FILL with byte_cnt=0.
- **FILL:**
  - fifo_renable = !fifo_empty.
  - On a pop, fifo_rdata is written to byte position byte_cnt, then byte_cnt increments.
  - A pop at byte_cnt=15 goes to HOLD and byte_cnt wraps to 0 on entry.
- **Flush in FILL:**
  - flush is acted on only when fifo_empty=1, so all packet bytes drain first.
  - If byte_cnt=0, flush_done pulses and the block stays in FILL. No block is emitted.
  - If byte_cnt>0, go to PAD.
- **PAD:**
  - In one cycle, bytes byte_cnt..15 are written with the pad value.
  - flush_done pulses and the block goes to HOLD.
  - fifo_renable=0.
- **HOLD:**
  - block_valid=1, and block_out stays stable until accepted.
  - fifo_renable=0, and flush is ignored.
  - block_valid && block_ready transfers the block: the assembly register clears to 0, byte_cnt=0, and the block returns to FILL.
- Reset in any state discards a partial or held block. No flush_done is issued.
- flush deasserting before flush_done is a source protocol violation; behaviour is undefined.

## Timing
- **Reset values:**
  - block_out=0, block_valid=0, flush_done=0, byte_cnt=0.
  - fifo_renable=0 while n_rst is low; the output is gated.
- Pops are back-to-back at one byte per cycle while the FIFO is not empty.
- For a full block, with the 16th pop in cycle N, block_valid=1 from cycle N+1.
- Flush path: PAD takes 1 cycle. flush_done and the PAD→HOLD transition fall in the same cycle, and block_valid=1 on the next cycle.
- If block_ready is high in the first HOLD cycle, the next pop can occur in the following cycle. This gives 17 cycles per block at best.
- block_ready is sampled only in HOLD.

## Configuration
- AES_PACKER_PKCS7_EN:
  - Defined: the pad byte value is BLOCK_BYTES − byte_cnt at PAD entry, per PKCS#7. For example, 5 bytes gives 11 pad bytes of 0x0B.
  - Undefined: pad bytes are 0x00.
- Under both settings, a flush at byte_cnt=0 emits no block.

## Structure
- aes_pkg:
  - Holds the state enum (FILL, PAD, HOLD), the BLOCK_BYTES localparam and a byte_t typedef.
  - Holds the block_t typedef, a packed array of 16 byte_t.
- Sub-module aes_pad_gen:
  - Inputs are byte_cnt and the current block.
  - Output is the padded block.
  - The macro is confined to this sub-module.

## Test plan
- **Full block:** feed bytes 0x00..0x0F back-to-back with block_ready=1 → exactly 16 pops, then block_valid one cycle later with block_out=0x000102…0F.
- **Backpressure:** a full block with block_ready held low for 10 cycles → block_out stable, no pops during HOLD, and one transfer when ready rises.
- **Partial flush:** feed 0xAA×5, FIFO empties, assert flush → PAD for 1 cycle, flush_done pulse, then block_valid. Bytes 5..15 are 0x0B with the macro and 0x00 without it.
- **Empty flush:** flush with byte_cnt=0 and FIFO empty → flush_done pulse the next cycle, with no block_valid.
- **Drain before flush:** assert flush while 3 bytes remain in the FIFO → all 3 bytes are popped first, then PAD.
- **Reset mid-operation:** assert n_rst after 7 bytes and again during HOLD → all outputs return to their reset values. The next 16 bytes form a clean block.
